// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared fetch-unit state encoding and constants
package mips_pkg;

  typedef enum logic {
    FETCH = 1'b0,
    VALID = 1'b1
  } fetch_state_e;

  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/npc_calc.sv
// rtl/npc_calc.sv - combinational next-PC select: jump, taken branch or sequential
module npc_calc
  import mips_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic        branch_i,
  input  logic [31:0] branch_off_i,
  input  logic        jump_i,
  input  logic [25:0] jump_target_i,
  output logic [31:0] next_pc_o
);

  logic [31:0] pc4;

  assign pc4 = pc_i + PC_STEP;

  // Jump has priority over branch when both are flagged.
  always_comb begin
    next_pc_o = pc4;
    if (jump_i) begin
      next_pc_o = {pc4[31:28], jump_target_i, 2'b00};
    end else if (branch_i) begin
      next_pc_o = pc4 + {branch_off_i[29:0], 2'b00};
    end
  end

endmodule

// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - instruction fetch front end: PC, memory handshake, held instruction
module ifetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          ADDR_W   = 5
) (
  input  logic              Clk,
  input  logic              Reset,
  output logic              ImReq,
  output logic [ADDR_W-1:0] ImAdr,
  input  logic [31:0]       ImRdata,
  input  logic              ImRdy,
  output logic [31:0]       Instr,
  output logic              InstrValid,
  output logic [31:0]       PC,
  input  logic              Stall,
  input  logic              Branch,
  input  logic [31:0]       BranchOff,
  input  logic              Jump,
  input  logic [25:0]       JumpTarget,
  output logic [31:0]       FetchCnt
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  cnt_q, cnt_d;
  logic [31:0]  next_pc;
  logic         req_raw;

  npc_calc u_npc_calc (
    .pc_i          (pc_q),
    .branch_i      (Branch),
    .branch_off_i  (BranchOff),
    .jump_i        (Jump),
    .jump_target_i (JumpTarget),
    .next_pc_o     (next_pc)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    cnt_d   = cnt_q;
    req_raw = 1'b0;
    case (state_q)
      FETCH: begin
        req_raw = 1'b1;
        if (ImRdy) begin
          instr_d = ImRdata;
          state_d = VALID;
        end
      end
      VALID: begin
        if (!Stall) begin
          pc_d    = next_pc;
          cnt_d   = cnt_q + 32'd1;
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  // Reset must drop the request combinationally so memory never sees a live fetch.
  assign ImReq      = req_raw && !Reset;
  assign ImAdr      = pc_q[ADDR_W+1:2];
  assign Instr      = instr_q;
  assign InstrValid = (state_q == VALID);
  assign PC         = pc_q;
  assign FetchCnt   = cnt_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0;
      cnt_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
